ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction queue entries; power of two, at least 2.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: clr  input  1  reset; asynchronous and active-low.
REQ-005 Port: mem_req  output  1  instruction memory read request; registered.
REQ-006 Port: mem_addr  output  32  word-aligned request address; registered; held stable while mem_req=1.
REQ-007 Port: mem_ack  input  1  response strobe; mem_rdata valid when mem_ack=1 and mem_req=1.
REQ-008 Port: mem_rdata  input  32  instruction word returned by memory.
REQ-009 Port: redirect  input  1  branch/jump taken; flush the queue and restart fetch.
REQ-010 Port: redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-011 Port: inst_valid  output  1  queue head holds an instruction; equals (count != 0).
REQ-012 Port: inst_ready  input  1  consumer accepts the head this cycle.
REQ-013 Port: inst  output  32  head instruction word; valid when inst_valid=1.
REQ-014 Port: inst_pc  output  32  address the head instruction was fetched from.

Function
REQ-015 Storage: DEPTH-entry circular FIFO of {pc, word}; read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-016 Registers: fpc (next fetch address), req_addr (drives mem_addr), state in {IDLE, REQ, DROP}; mem_req=1 in REQ and DROP only.
REQ-017 Pop: occurs when inst_valid & inst_ready; head advances at the clock edge.
REQ-018 At most one request is outstanding at any time.
REQ-019 IDLE, no redirect: if count after this cycle's pop < DEPTH, then req_addr<=fpc and state->REQ; otherwise stay IDLE.
REQ-020 REQ, mem_ack=1, no redirect: push {req_addr, mem_rdata}; fpc<=fpc+4.
REQ-021 After the push in REQ-020: if count after push and pop < DEPTH, then req_addr<=fpc+4 and stay REQ; otherwise state->IDLE. Zero-wait memory therefore sustains one instruction per cycle.
REQ-022 REQ, mem_ack=0, no redirect: hold state, req_addr and mem_req.
REQ-023 Redirect, any state: the queue is emptied (count<=0, pointers equal) and fpc<=redirect_pc with bits [1:0]=0.
REQ-024 Redirect overrides any push in that cycle.
REQ-025 Redirect in the same cycle as a pop: the consumer keeps the popped instruction; no other entry survives.
REQ-026 Redirect in REQ with mem_ack=0: state->DROP; mem_req stays 1 at the old req_addr, which is held until the ack.
REQ-027 Redirect in REQ with mem_ack=1: the response is discarded; state->IDLE.
REQ-028 Redirect in IDLE: state stays IDLE; a request to the new fpc is issued on the following edge.
REQ-029 DROP: mem_ack=1 discards mem_rdata and moves state->IDLE; a redirect while in DROP updates fpc only.
REQ-030 Latency: a word acked at edge N drives inst_valid=1 from edge N onward; a redirect at edge N raises mem_req at the new address no earlier than edge N+1.
REQ-031 fpc arithmetic: 32-bit, wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no error.
REQ-032 Full queue: no request is issued, so no push can be lost; an empty queue with inst_ready=1 does not pop.

Reset
REQ-033 clr=0 asynchronously forces the following reset values:
- state=IDLE, fpc=RESET_PC, req_addr=0;
- count=0 and both pointers=0;
- mem_req=0, inst_valid=0, mem_addr=0;
- inst and inst_pc=0.
REQ-034 Reset during an outstanding request abandons the request; a mem_ack arriving after reset release while in IDLE is ignored.
REQ-035 The first request after reset release: mem_req=1 with mem_addr=RESET_PC on the first rising edge after clr returns high.

Verification
REQ-036 Reset release, zero-wait memory (mem_ack=mem_req), inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8 on consecutive cycles; mem_rdata echoed on inst.
REQ-037 inst_ready=0, ack always 1, DEPTH=4 -> four pushes (pc 0x0..0xC), then mem_req=0, count=4; inst_ready=1 for one cycle -> a request at 0x10 is reissued.
REQ-038 Two ack-free cycles in REQ, then redirect to 0x100 -> state DROP, mem_addr held at the old address; ack -> data dropped; then mem_req with mem_addr=0x100; first inst_pc=0x100.
REQ-039 Redirect to 0x203 in the same cycle as mem_ack -> acked word absent from the queue; next mem_addr=0x200.
REQ-040 Three entries queued, redirect coinciding with a pop -> the popped head is accepted, inst_valid=0 next cycle, count=0.
REQ-041 clr pulsed low mid-request with count=2 -> all outputs at reset values immediately; mem_req=1 with mem_addr=RESET_PC one edge after release.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues one word read at a time and buffers
// returned instructions with their fetch addresses in a small circular queue.
//
// state  | meaning
// IDLE   | no request outstanding; issue when the queue has room
// REQ    | request at req_addr outstanding, response will be pushed
// DROP   | request outstanding but a redirect made its response stale
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];
    logic [31:0]   fifo_word_d [DEPTH];

    logic          pop;
    logic          push;
    logic [CW-1:0] count_pop;

    always_comb begin
        pop       = (count_q != '0) && inst_ready;
        push      = (state_q == S_REQ) && mem_ack && !redirect;
        count_pop = count_q - CW'(pop);

        state_d     = state_q;
        fpc_d       = fpc_q;
        req_addr_d  = req_addr_q;
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_pop;
        fifo_pc_d   = fifo_pc_q;
        fifo_word_d = fifo_word_q;

        if (push) begin
            fifo_pc_d[wr_ptr_q]   = req_addr_q;
            fifo_word_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            count_d               = count_pop + CW'(1);
            fpc_d                 = fpc_q + 32'd4;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect && (count_pop < DEPTH_C)) begin
                    req_addr_d = fpc_q;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    // A late ack must still be absorbed, so wait for it in DROP
                    state_d = mem_ack ? S_IDLE : S_DROP;
                end else if (mem_ack) begin
                    if ((count_pop + CW'(1)) < DEPTH_C) begin
                        req_addr_d = fpc_q + 32'd4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fpc_d    = {redirect_pc[31:2], 2'b00};
        end

        mem_req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            fpc_q      <= RESET_PC;
            req_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            fpc_q       <= fpc_d;
            req_addr_q  <= req_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_word_q <= fifo_word_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = fifo_word_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, full queue, redirects,
// mid-request reset and fetch-address wrap, with hand-computed expectations.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign mem_ack   = ack_auto ? mem_req : ack_man;
    assign mem_rdata = word_of(mem_addr);

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .clr(clr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 clr = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        clr = 1'b1;
        step();
    endtask

    initial begin
        // Reset state, then streaming with zero-wait memory
        do_reset();
        step();
        chk("rst_hold_req", {31'b0, mem_req}, 32'h0);
        ack_auto = 1'b1; inst_ready = 1'b1;
        release_reset();
        chk("first_req", {31'b0, mem_req}, 32'h1);
        chk("first_addr", mem_addr, 32'h0);
        chk("first_valid", {31'b0, inst_valid}, 32'h0);
        step();
        chk("s_pc0", inst_pc, 32'h0);
        chk("s_inst0", inst, word_of(32'h0));
        chk("s_addr4", mem_addr, 32'h4);
        step();
        chk("s_pc4", inst_pc, 32'h4);
        chk("s_inst4", inst, word_of(32'h4));
        step();
        chk("s_pc8", inst_pc, 32'h8);
        chk("s_inst8", inst, word_of(32'h8));

        // Fill the queue with the consumer stalled
        inst_ready = 1'b0;
        do_reset();
        release_reset();
        step(); step(); step(); step();
        chk("full_req", {31'b0, mem_req}, 32'h0);
        chk("full_valid", {31'b0, inst_valid}, 32'h1);
        chk("full_head", inst_pc, 32'h0);
        step();
        chk("full_hold_req", {31'b0, mem_req}, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("reissue_req", {31'b0, mem_req}, 32'h1);
        chk("reissue_addr", mem_addr, 32'h10);
        chk("reissue_head", inst_pc, 32'h4);
        step();
        chk("refill_req", {31'b0, mem_req}, 32'h0);
        chk("refill_head", inst_pc, 32'h4);

        // Redirect while a request waits for its ack
        ack_auto = 1'b0; ack_man = 1'b0; inst_ready = 1'b1;
        do_reset();
        release_reset();
        step(); step();
        chk("wait_req", {31'b0, mem_req}, 32'h1);
        chk("wait_addr", mem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("drop_req", {31'b0, mem_req}, 32'h1);
        chk("drop_addr", mem_addr, 32'h0);
        chk("drop_valid", {31'b0, inst_valid}, 32'h0);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("dropped_req", {31'b0, mem_req}, 32'h0);
        chk("dropped_valid", {31'b0, inst_valid}, 32'h0);
        step();
        chk("redir_req", {31'b0, mem_req}, 32'h1);
        chk("redir_addr", mem_addr, 32'h100);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("redir_pc", inst_pc, 32'h100);
        chk("redir_inst", inst, word_of(32'h100));
        chk("redir_next_addr", mem_addr, 32'h104);

        // Redirect coinciding with an ack (and a pop of the head)
        redirect = 1'b1; redirect_pc = 32'h203; ack_man = 1'b1;
        step();
        redirect = 1'b0; ack_man = 1'b0;
        chk("ackredir_valid", {31'b0, inst_valid}, 32'h0);
        chk("ackredir_req", {31'b0, mem_req}, 32'h0);
        step();
        chk("ackredir_addr", mem_addr, 32'h200);
        chk("ackredir_req2", {31'b0, mem_req}, 32'h1);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("ackredir_pc", inst_pc, 32'h200);

        // Three entries queued, redirect together with a pop
        inst_ready = 1'b0; ack_auto = 1'b1;
        do_reset();
        release_reset();
        step(); step(); step();
        ack_auto = 1'b0;
        chk("q3_head", inst_pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
        step();
        redirect = 1'b0; inst_ready = 1'b0;
        chk("popredir_valid", {31'b0, inst_valid}, 32'h0);
        chk("popredir_req", {31'b0, mem_req}, 32'h1);
        chk("popredir_addr", mem_addr, 32'hC);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("popredir_idle", {31'b0, mem_req}, 32'h0);
        step();
        chk("popredir_new", mem_addr, 32'h40);

        // Reset in the middle of a request with two entries queued
        ack_auto = 1'b1;
        do_reset();
        release_reset();
        step(); step();
        chk("mid_count2", {31'b0, inst_valid}, 32'h1);
        chk("mid_req", mem_addr, 32'h8);
        ack_auto = 1'b0; ack_man = 1'b1;
        do_reset();
        release_reset();
        ack_man = 1'b0;
        chk("mid_rel_req", {31'b0, mem_req}, 32'h1);
        chk("mid_rel_addr", mem_addr, 32'h0);
        chk("mid_rel_valid", {31'b0, inst_valid}, 32'h0);

        // Fetch address wraps past the top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        step();
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_next", mem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
